// File: rtl/rtc_seq_ctrl.sv
// rtl/rtc_seq_ctrl.sv - RTC bus frame sequencer: config check, read burst, arbitrated write
// Outputs are registered from next-state values so they line up with the frame count and clear on reset.
module rtc_seq_ctrl #(
    parameter int NCH      = 3,
    parameter int NCFG     = 2,
    parameter int CW       = 10,
    parameter int T_CHECK  = 32,
    parameter int T_READ   = 62,
    parameter int RD_LEN   = 3,
    parameter int T_WRITE  = 382,
    parameter int WR_LEN   = 4,
    parameter int T_PERIOD = 489,
    parameter bit ARB_RR   = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [NCH-1:0]  req,
    input  logic [NCFG-1:0] cfg_in,
    output logic [NCH-1:0]  cmd_en,
    output logic [NCH-1:0]  wr_en,
    output logic            rd_en,
    output logic            cfg_chg,
    output logic            lock,
    output logic            frame_start
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW = (WR_LEN > 1) ? $clog2(WR_LEN) : 1;

    typedef enum logic [1:0] {S_RUN, S_CMD, S_WR, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NCFG-1:0] shadow, shadow_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt;
    logic [NCH-1:0]  gnt, gnt_nxt;
    logic [WW-1:0]   wr_cnt, wr_cnt_nxt;
    logic            lock_nxt, chg_nxt;
    logic [NCH-1:0]  cmd_nxt, wr_nxt;
    logic            rd_nxt, fs_nxt;

    // Arbitration: scan circularly from the base index, first requester wins.
    logic [PW-1:0]   rr_sel;
    logic [PW-1:0]   gnt_idx;
    logic [NCH-1:0]  gnt_oh;
    logic            found;

    always_comb begin
        rr_sel  = ARB_RR ? rr_ptr : '0;
        gnt_idx = '0;
        gnt_oh  = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[(int'(rr_sel) + i) % NCH]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_sel) + i) % NCH);
                gnt_oh[(int'(rr_sel) + i) % NCH] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        rr_nxt     = rr_ptr;
        gnt_nxt    = gnt;
        wr_cnt_nxt = wr_cnt;
        lock_nxt   = lock;
        chg_nxt    = 1'b0;
        case (state)
            S_RUN: begin
                cnt_nxt = (cnt == CW'(T_PERIOD)) ? '0 : cnt + 1'b1;
                if (cnt == CW'(T_CHECK)) begin
                    chg_nxt = (cfg_in != shadow);
                    if (|req) lock_nxt = 1'b1;
                end
                if (cnt == CW'(T_WRITE)) begin
                    if (|req) begin
                        gnt_nxt   = gnt_oh;
                        cnt_nxt   = cnt;
                        state_nxt = S_CMD;
                        if (ARB_RR)
                            rr_nxt = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        cnt_nxt  = '0;
                        lock_nxt = 1'b0;
                    end
                end
            end
            S_CMD: begin
                state_nxt  = S_WR;
                wr_cnt_nxt = WW'(WR_LEN - 1);
            end
            S_WR: begin
                if (wr_cnt == '0)
                    state_nxt = S_DONE;
                else
                    wr_cnt_nxt = wr_cnt - 1'b1;
            end
            S_DONE: begin
                shadow_nxt = cfg_in;
                lock_nxt   = 1'b0;
                cnt_nxt    = CW'(T_WRITE + 1);
                state_nxt  = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase

        cmd_nxt = (state_nxt == S_CMD) ? gnt_nxt : '0;
        wr_nxt  = (state_nxt == S_WR)  ? gnt_nxt : '0;
        rd_nxt  = (state_nxt == S_RUN) && (cnt_nxt >= CW'(T_READ))
                  && (cnt_nxt < CW'(T_READ + RD_LEN));
        fs_nxt  = (state_nxt == S_RUN) && (cnt_nxt == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_RUN;
            cnt         <= '0;
            shadow      <= '0;
            rr_ptr      <= '0;
            gnt         <= '0;
            wr_cnt      <= '0;
            lock        <= 1'b0;
            cfg_chg     <= 1'b0;
            cmd_en      <= '0;
            wr_en       <= '0;
            rd_en       <= 1'b0;
            frame_start <= 1'b0;
        end else if (!stall) begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shadow      <= shadow_nxt;
            rr_ptr      <= rr_nxt;
            gnt         <= gnt_nxt;
            wr_cnt      <= wr_cnt_nxt;
            lock        <= lock_nxt;
            cfg_chg     <= chg_nxt;
            cmd_en      <= cmd_nxt;
            wr_en       <= wr_nxt;
            rd_en       <= rd_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
